// File: rtl/watchdog_multi_if.sv
// Register/control bundle of the multi-channel watchdog.
// The master drives configuration, service and readback selects; the slave returns status.
interface watchdog_multi_if #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PRESC_W-1:0] presc_div;
  logic [N_CH-1:0]    en;
  logic [N_CH-1:0]    kick;
  logic [N_CH-1:0]    clr;
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [CNT_W-1:0]   cfg_timeout;
  logic [CNT_W-1:0]   cfg_window;
  logic [CH_W-1:0]    rd_ch;
  logic [CNT_W-1:0]   rd_count;
  logic [2*N_CH-1:0]  ch_state;
  logic [N_CH-1:0]    expired;
  logic [N_CH-1:0]    early_kick;
  logic               irq;

  modport master (
    output presc_div, en, kick, clr, cfg_we, cfg_ch, cfg_timeout, cfg_window, rd_ch,
    input  rd_count, ch_state, expired, early_kick, irq
  );

  modport slave (
    input  presc_div, en, kick, clr, cfg_we, cfg_ch, cfg_timeout, cfg_window, rd_ch,
    output rd_count, ch_state, expired, early_kick, irq
  );
endinterface

// File: rtl/watchdog_multi.sv
// N independent watchdog channels sharing one prescaler tick, with optional
// kick window, sticky expiry/early-kick flags, a combined irq and counter readback.
module watchdog_multi #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  watchdog_multi_if.slave  bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10,
    ST_BAD  = 2'b11
  } ch_state_e;

  // Reset release is re-timed so no channel can leave IDLE on a metastable edge.
  logic [1:0] sync_q;
  logic       run_ok;
  assign run_ok = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], 1'b1};
  end

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;

  always_comb begin
    tick    = (presc_q == bus.presc_div);
    presc_d = (presc_q >= bus.presc_div) ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      presc_q <= '0;
    else if (run_ok) presc_q <= presc_d;
  end

  logic [CNT_W-1:0] cnt_all [N_CH];
  logic [N_CH-1:0]  exp_vec;
  logic [N_CH-1:0]  early_vec;

  for (genvar gi = 0; gi < N_CH; gi++) begin : gen_ch
    localparam logic [CH_W-1:0] CH_ID = CH_W'(gi);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] timeout_q, window_q;
    logic             expired_q, early_q;
    logic             exp_set, early_set, kick_ok;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      exp_set   = 1'b0;
      early_set = 1'b0;
      kick_ok   = (window_q == '0) || (cnt_q >= window_q);
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (bus.en[gi]) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!bus.en[gi]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (bus.kick[gi]) begin
            // A legal kick outranks a simultaneous timeout tick.
            if (kick_ok) begin
              cnt_d = '0;
            end else begin
              state_d   = ST_DONE;
              early_set = 1'b1;
            end
          end else if (tick) begin
            if (cnt_q >= timeout_q) begin
              state_d = ST_DONE;
              exp_set = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!bus.en[gi] || bus.clr[gi]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        timeout_q <= CNT_MAX;
        window_q  <= '0;
        expired_q <= 1'b0;
        early_q   <= 1'b0;
      end else if (run_ok) begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        // Setting a flag wins over a clear arriving in the same cycle.
        expired_q <= exp_set | (expired_q & ~bus.clr[gi]);
        early_q   <= early_set | (early_q & ~bus.clr[gi]);
        if (bus.cfg_we && (bus.cfg_ch == CH_ID)) begin
          timeout_q <= bus.cfg_timeout;
          window_q  <= bus.cfg_window;
        end
      end
    end

    assign cnt_all[gi]               = cnt_q;
    assign exp_vec[gi]               = expired_q;
    assign early_vec[gi]             = early_q;
    assign bus.ch_state[2*gi +: 2]   = state_q;
  end

  logic [CNT_W-1:0] rd_sel;
  logic [CNT_W-1:0] rd_count_q;
  logic             irq_q;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.rd_ch == CH_W'(i)) rd_sel = cnt_all[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
      irq_q      <= 1'b0;
    end else if (run_ok) begin
      rd_count_q <= rd_sel;
      irq_q      <= |{exp_vec, early_vec};
    end
  end

  assign bus.rd_count   = rd_count_q;
  assign bus.irq        = irq_q;
  assign bus.expired    = exp_vec;
  assign bus.early_kick = early_vec;
endmodule

// File: tb/tb_watchdog_multi.sv
// Directed and randomized checks of watchdog_multi against a cycle-level
// behavioural model of the channel rules kept in plain integers.
module tb_watchdog_multi;
  localparam int N_CH    = 3;
  localparam int CNT_W   = 4;
  localparam int PRESC_W = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DONE  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  watchdog_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) bus();

  watchdog_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    checks   = 0;
  int    failures = 0;
  string scen     = "init";

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s got=%0h expected=%0h t=%0t", scen, tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int m_presc, m_sync, m_rd;
  bit m_irq;
  int m_st  [N_CH];
  int m_cnt [N_CH];
  int m_to  [N_CH];
  int m_win [N_CH];
  bit m_exp [N_CH];
  bit m_ek  [N_CH];

  function automatic void model_reset();
    m_presc = 0;
    m_sync  = 0;
    m_rd    = 0;
    m_irq   = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      m_st[c]  = S_IDLE;
      m_cnt[c] = 0;
      m_to[c]  = CMAX;
      m_win[c] = 0;
      m_exp[c] = 1'b0;
      m_ek[c]  = 1'b0;
    end
  endfunction

  function automatic void model_step();
    int nst [N_CH];
    int ncnt [N_CH];
    bit nexp [N_CH];
    bit nek [N_CH];
    int pd, rc, rd_n;
    bit tick, irq_n, set_e, set_k;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_sync < 2) begin
      m_sync++;
      return;
    end
    pd    = int'(bus.presc_div);
    tick  = (m_presc == pd);
    irq_n = 1'b0;
    for (int c = 0; c < N_CH; c++) irq_n = irq_n | m_exp[c] | m_ek[c];
    rc   = int'(bus.rd_ch);
    rd_n = 0;
    if (rc < N_CH) rd_n = m_cnt[rc];
    for (int c = 0; c < N_CH; c++) begin
      nst[c]  = m_st[c];
      ncnt[c] = m_cnt[c];
      set_e   = 1'b0;
      set_k   = 1'b0;
      if (!bus.en[c]) begin
        nst[c] = S_IDLE; ncnt[c] = 0;
      end else if (m_st[c] == S_IDLE) begin
        nst[c] = S_RUN; ncnt[c] = 0;
      end else if (m_st[c] == S_DONE) begin
        if (bus.clr[c]) begin nst[c] = S_IDLE; ncnt[c] = 0; end
      end else if (bus.kick[c]) begin
        if (m_win[c] == 0 || m_cnt[c] >= m_win[c]) ncnt[c] = 0;
        else begin nst[c] = S_DONE; set_k = 1'b1; end
      end else if (tick) begin
        if (m_cnt[c] >= m_to[c]) begin nst[c] = S_DONE; set_e = 1'b1; end
        else ncnt[c] = (m_cnt[c] + 1 > CMAX) ? CMAX : m_cnt[c] + 1;
      end
      nexp[c] = set_e | (m_exp[c] & !bus.clr[c]);
      nek[c]  = set_k | (m_ek[c] & !bus.clr[c]);
    end
    for (int c = 0; c < N_CH; c++) begin
      m_st[c]  = nst[c];
      m_cnt[c] = ncnt[c];
      m_exp[c] = nexp[c];
      m_ek[c]  = nek[c];
    end
    if (bus.cfg_we && int'(bus.cfg_ch) < N_CH) begin
      m_to[int'(bus.cfg_ch)]  = int'(bus.cfg_timeout);
      m_win[int'(bus.cfg_ch)] = int'(bus.cfg_window);
    end
    m_irq   = irq_n;
    m_rd    = rd_n;
    m_presc = (m_presc >= pd) ? 0 : m_presc + 1;
  endfunction

  task automatic compare_all();
    logic [31:0] st_v, ex_v, ek_v;
    st_v = '0; ex_v = '0; ek_v = '0;
    for (int c = 0; c < N_CH; c++) begin
      st_v = st_v | (32'(m_st[c]) << (2*c));
      ex_v[c] = m_exp[c];
      ek_v[c] = m_ek[c];
    end
    check_val("ch_state", 32'(bus.ch_state), st_v);
    check_val("expired", 32'(bus.expired), ex_v);
    check_val("early_kick", 32'(bus.early_kick), ek_v);
    check_val("irq", 32'(bus.irq), 32'(m_irq));
    check_val("rd_count", 32'(bus.rd_count), 32'(m_rd));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_val("rst_state", 32'(bus.ch_state), 32'd0);
    steps(3);
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input int ch, input int to, input int win);
    bus.cfg_we      = 1'b1;
    bus.cfg_ch      = 2'(ch);
    bus.cfg_timeout = 4'(to);
    bus.cfg_window  = 4'(win);
    step();
    bus.cfg_we = 1'b0;
  endtask

  // Steps until channel ch shows DONE; returns steps taken (bounded).
  task automatic wait_done(input int ch, input int limit, output int n);
    n = 0;
    while (bus.ch_state[2*ch +: 2] != 2'b10 && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic idle_inputs();
    bus.en = '0; bus.kick = '0; bus.clr = '0; bus.cfg_we = 1'b0;
    bus.cfg_ch = '0; bus.cfg_timeout = '0; bus.cfg_window = '0; bus.rd_ch = '0;
  endtask

  initial begin
    int n, maxc, c0, f0;
    idle_inputs();
    bus.presc_div = '0;
    #2;

    // Basic timeout with tick every cycle
    scen = "timeout5"; c0 = checks; f0 = failures;
    do_reset(); steps(3);
    cfg_write(0, 5, 0);
    bus.en = 3'b001;
    step();
    wait_done(0, 50, n);
    check_val("ticks_to_expire", 32'(n), 32'd6);
    check_val("expired0", 32'(bus.expired[0]), 32'd1);
    check_val("irq_same_cycle", 32'(bus.irq), 32'd0);
    step();
    check_val("irq_next_cycle", 32'(bus.irq), 32'd1);
    bus.en = '0; bus.clr = 3'b001; step(); bus.clr = '0; step();
    $display("scenario %s: checks=%0d failures=%0d", scen, checks - c0, failures - f0);

    // Periodic servicing keeps the channel alive
    scen = "kick_periodic"; c0 = checks; f0 = failures;
    bus.presc_div = 8'd3;
    do_reset(); steps(3);
    cfg_write(2, 10, 0);
    bus.rd_ch = 2'd2; bus.en = 3'b100;
    step();
    maxc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.kick[2] = (cyc % 32 == 31);
      step();
      if (int'(bus.rd_count) > maxc) maxc = int'(bus.rd_count);
    end
    bus.kick = '0;
    check_val("max_count_le8", 32'(maxc <= 8), 32'd1);
    check_val("still_run", 32'(bus.ch_state[5:4]), 32'd1);
    check_val("irq_low", 32'(bus.irq), 32'd0);
    $display("scenario %s: checks=%0d failures=%0d", scen, checks - c0, failures - f0);

    // Early kick inside window, then clear
    scen = "window"; c0 = checks; f0 = failures;
    bus.presc_div = 8'd0; bus.en = '0;
    do_reset(); steps(3);
    cfg_write(1, 10, 4);
    bus.en = 3'b010; bus.rd_ch = 2'd1;
    steps(3);
    bus.kick = 3'b010; step(); bus.kick = '0;
    check_val("early1", 32'(bus.early_kick[1]), 32'd1);
    check_val("done1", 32'(bus.ch_state[3:2]), 32'd2);
    step();
    check_val("irq_up", 32'(bus.irq), 32'd1);
    bus.clr = 3'b010; bus.en = '0; step(); bus.clr = '0;
    check_val("early_cleared", 32'(bus.early_kick[1]), 32'd0);
    check_val("idle1", 32'(bus.ch_state[3:2]), 32'd0);
    check_val("irq_lag", 32'(bus.irq), 32'd1);
    step();
    check_val("irq_down", 32'(bus.irq), 32'd0);
    $display("scenario %s: checks=%0d failures=%0d", scen, checks - c0, failures - f0);

    // Kick vs timeout in one cycle; clear vs expiry in one cycle
    scen = "collide"; c0 = checks; f0 = failures;
    cfg_write(0, 3, 0);
    bus.en = 3'b001; bus.rd_ch = 2'd0;
    step(); steps(3);
    bus.kick = 3'b001; step(); bus.kick = '0;
    check_val("kick_wins_state", 32'(bus.ch_state[1:0]), 32'd1);
    check_val("kick_wins_exp", 32'(bus.expired[0]), 32'd0);
    bus.clr = 3'b001;
    steps(4);
    check_val("set_beats_clr", 32'(bus.expired[0]), 32'd1);
    check_val("set_beats_clr_st", 32'(bus.ch_state[1:0]), 32'd2);
    step(); bus.clr = '0; bus.en = '0; step();
    $display("scenario %s: checks=%0d failures=%0d", scen, checks - c0, failures - f0);

    // Full-range count with reset-default timeout, no wrap
    scen = "saturate"; c0 = checks; f0 = failures;
    do_reset(); steps(3);
    bus.en = 3'b001; bus.rd_ch = 2'd0;
    step();
    wait_done(0, 60, n);
    check_val("ticks_full", 32'(n), 32'd16);
    check_val("count_at_done", 32'(bus.rd_count), 32'd15);
    bus.en = '0; bus.clr = 3'b001; step(); bus.clr = '0;
    $display("scenario %s: checks=%0d failures=%0d", scen, checks - c0, failures - f0);

    // Reset in the middle of a run
    scen = "mid_reset"; c0 = checks; f0 = failures;
    cfg_write(1, 12, 0);
    bus.en = 3'b010; bus.rd_ch = 2'd1;
    step(); steps(7);
    check_val("count7", 32'(dut.gen_ch[1].cnt_q), 32'd7);
    #2;
    do_reset();
    check_val("no_irq", 32'(bus.irq), 32'd0);
    wait_done(1, 60, n);
    check_val("sync_plus_default", 32'(n), 32'd19);
    bus.en = '0; bus.clr = 3'b111; step(); bus.clr = '0;
    $display("scenario %s: checks=%0d failures=%0d", scen, checks - c0, failures - f0);

    // Randomized traffic
    for (int seg = 0; seg < 3; seg++) begin
      scen = $sformatf("random%0d", seg); c0 = checks; f0 = failures;
      idle_inputs();
      bus.presc_div = 8'($urandom_range(0, 3));
      do_reset();
      bus.en = 3'b111;
      for (int cyc = 0; cyc < 500; cyc++) begin
        for (int c = 0; c < N_CH; c++) begin
          if ($urandom_range(0, 31) == 0) bus.en[c] = ~bus.en[c];
          bus.kick[c] = ($urandom_range(0, 5) == 0);
          bus.clr[c]  = ($urandom_range(0, 19) == 0);
        end
        bus.cfg_we      = ($urandom_range(0, 23) == 0);
        bus.cfg_ch      = 2'($urandom_range(0, 3));
        bus.cfg_timeout = 4'($urandom_range(0, 15));
        bus.cfg_window  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
        bus.rd_ch       = 2'($urandom_range(0, 3));
        step();
      end
      $display("scenario %s: checks=%0d failures=%0d", scen, checks - c0, failures - f0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/watchdog_multi.md
WATCHDOG_MULTI -- requirements
Module: watchdog_multi

Interface
REQ-001 Parameter N_CH, default 4, number of independent watchdog channels (1..16).
REQ-002 Parameter CNT_W, default 16, width of each channel counter, timeout and window value.
REQ-003 Parameter PRESC_W, default 8, width of the shared prescaler divider.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 presc_div  in  PRESC_W  tick period minus one.
REQ-008 en  in  N_CH  per-channel enable.
REQ-009 kick  in  N_CH  per-channel service pulse, one cycle per kick.
REQ-010 clr  in  N_CH  per-channel flag clear and DONE release.
REQ-011 cfg_we  in  1  configuration write strobe.
REQ-012 cfg_ch  in  clog2(N_CH) (min 1)  target channel of cfg write.
REQ-013 cfg_timeout  in  CNT_W  timeout value written to cfg_ch.
REQ-014 cfg_window  in  CNT_W  earliest legal kick count written to cfg_ch; 0 disables window mode.
REQ-015 rd_ch  in  clog2(N_CH) (min 1)  channel selected for readback.
REQ-016 rd_count  out  CNT_W  registered counter of rd_ch.
REQ-017 ch_state  out  2*N_CH  per-channel state, IDLE=00, RUN=01, DONE=10.
REQ-018 expired  out  N_CH  sticky timeout flag.
REQ-019 early_kick  out  N_CH  sticky window-violation flag.
REQ-020 irq  out  1  registered OR of all expired and early_kick bits.

Function
REQ-021 The shared prescaler SHALL count 0..presc_div and assert an internal tick for one cycle when it equals presc_div, then return to 0; presc_div=0 gives a tick every cycle.
REQ-022 Each channel SHALL hold state IDLE/RUN/DONE; encoding 11 SHALL never occur and SHALL recover to IDLE.
REQ-023 IDLE: counter held at 0; en high -> RUN on next edge with counter 0.
REQ-024 RUN: on tick counter increments by 1, saturating at all-ones (no wrap).
REQ-025 RUN: if counter >= timeout on a tick without a kick -> DONE, expired set, same edge.
REQ-026 RUN: kick with window=0 or counter >= window -> counter reset to 0, stay RUN.
REQ-027 RUN: kick with window != 0 and counter < window -> DONE, early_kick set, counter holds.
REQ-028 Legal kick and timeout tick in the same cycle: kick wins, counter 0, no expiry.
REQ-029 DONE: counter frozen, kicks ignored; clr -> IDLE and clears expired/early_kick of that channel.
REQ-030 en low in RUN or DONE -> IDLE, counter 0; flags unaffected (cleared only by clr or reset).
REQ-031 clr in the same cycle as a new flag set: set wins, state goes DONE.
REQ-032 timeout=0: channel expires on first tick after entering RUN.
REQ-033 cfg_we writes timeout and window of cfg_ch, effective from next cycle; if new timeout <= current count in RUN, expiry occurs on next tick; cfg_ch >= N_CH ignored.
REQ-034 rd_count SHALL present counter of rd_ch with 1-cycle latency; rd_ch >= N_CH returns 0.
REQ-035 irq SHALL assert one cycle after any flag sets and deassert one cycle after all flags clear.

Reset
REQ-036 On rst_n low, immediately: all channels IDLE, counters 0, prescaler 0, expired/early_kick/irq/rd_count 0.
REQ-037 Per-channel config SHALL reset to timeout = all-ones, window = 0.
REQ-038 Reset asserted mid-RUN SHALL abort without flag set; release SHALL be synchronised (2-flop) before state leaves IDLE.

Verification
REQ-039 presc_div=0, ch0 timeout=5, en[0]=1, no kicks -> ch0 DONE and expired[0]=1 on sixth tick after RUN, irq next cycle.
REQ-040 presc_div=3, timeout=10, kick every 8 ticks -> ch stays RUN indefinitely, count never exceeds 8, irq=0.
REQ-041 window=4, timeout=10, kick at count 2 -> early_kick set, DONE; clr -> IDLE, flags 0, irq drops one cycle later.
REQ-042 Kick and timeout tick same cycle (count=timeout) -> count 0, RUN, expired stays 0; clr and expiry same cycle -> expired=1.
REQ-043 CNT_W=4, timeout=15, window=0, kick held off with tick each cycle -> count saturates at 15 with expiry, no wrap to 0.
REQ-044 rst_n pulsed low while ch1 RUN at count 7 -> ch1 IDLE, count 0, config back to defaults, no irq.
